prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104; clock cycles per UART bit (12 MHz / 115200).
REQ-002 SHALL have parameter ADDR_W, default 12; program-memory address width.
REQ-003 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx  input  1  UART 8N1 serial line (idle high, LSB first).
REQ-006 SHALL have port prog_addr  output  ADDR_W  program-memory write address.
REQ-007 SHALL have port prog_data  output  16  program-memory write data (Hack instruction).
REQ-008 SHALL have port prog_we  output  1  one-cycle write strobe for prog_addr/prog_data.
REQ-009 SHALL have port cpu_hold  output  1  holds the CPU in reset while a load is in progress or failed.
REQ-010 SHALL have port busy  output  1  high from sync byte until DONE or ERR.
REQ-011 SHALL have port error  output  1  high in ERR state.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-013 SHALL detect a start bit on a synchronized high-to-low edge, re-check low at CLKS_PER_BIT/2, then sample 8 data bits and 1 stop bit every CLKS_PER_BIT cycles.
REQ-014 SHALL discard a start bit that is high at the mid-point check (glitch) and return to line idle.
REQ-015 SHALL treat a stop bit sampled low as a framing error; byte discarded; FSM enters ERR unless it is in IDLE.
REQ-016 SHALL run the byte FSM IDLE -> LEN_HI -> LEN_LO -> DATA_HI -> DATA_LO -> (CSUM_HI -> CSUM_LO) -> DONE; ERR is reachable from any non-IDLE state.
REQ-017 SHALL leave IDLE only on received byte 0xA5; other bytes in IDLE are ignored.
REQ-018 SHALL interpret LEN_HI:LEN_LO as big-endian word count N.
REQ-019 SHALL go to DONE immediately after LEN_LO when N = 0, with no writes.
REQ-020 SHALL go to ERR after LEN_LO when N > 2^ADDR_W.
REQ-021 SHALL assemble each big-endian word and assert prog_we for exactly one cycle, the cycle after the DATA_LO byte completes, with prog_data = word.
REQ-022 SHALL start prog_addr at 0 for each load and increment it by 1 after each write; the last write uses address N-1 (no wrap, guaranteed by REQ-020).
REQ-023 SHALL hold prog_addr and prog_data stable whenever prog_we is low.
REQ-024 SHALL assert cpu_hold and busy from the cycle after the 0xA5 byte completes; busy deasserts on entering DONE or ERR; cpu_hold deasserts on entering DONE.
REQ-025 SHALL keep cpu_hold and error high in ERR; a received 0xA5 in ERR starts a new load (clears error, resets address to 0).
REQ-026 SHALL return DONE to IDLE on the next cycle; a later 0xA5 starts a new load.

Reset
REQ-027 SHALL, while reset_n is low, asynchronously force: FSM = IDLE, UART receiver idle, prog_addr = 0, prog_data = 0, prog_we = 0, cpu_hold = 0, busy = 0, error = 0.
REQ-028 SHALL abort a load in progress on reset_n assertion with no further prog_we pulses; memory already written is left as is.

Configuration
REQ-029 SHALL, with macro PROG_LOADER_CHECKSUM_EN defined, expect after the last data word (or after LEN_LO when N = 0) a big-endian 16-bit checksum equal to the mod-2^16 sum of all data words; match -> DONE, mismatch -> ERR.
REQ-030 SHALL, without PROG_LOADER_CHECKSUM_EN, omit states CSUM_HI/CSUM_LO and the accumulator, entering DONE directly after the last DATA_LO.

Verification
REQ-031 SHALL cover: bytes A5 00 02 12 34 AB CD (checksum off) -> prog_we pulses write 0x1234@0 and 0xABCD@1, cpu_hold high throughout, low after DONE, error = 0.
REQ-032 SHALL cover: checksum on, A5 00 02 12 34 AB CD BE 01 -> two writes, DONE; same stream ending BE 02 -> ERR, error = 1, cpu_hold = 1.
REQ-033 SHALL cover: A5 10 01 (N = 4097, ADDR_W = 12) -> ERR after LEN_LO, zero writes.
REQ-034 SHALL cover: framing error (stop bit low) on the second data byte -> ERR, no write for that word; then a fresh A5 00 01 00 07 -> write 0x0007@0, error cleared.
REQ-035 SHALL cover: reset_n pulsed low mid-word -> all outputs at reset values in the same cycle, no further writes, and a subsequent full load succeeds from address 0.
REQ-036 SHALL cover: a 0.3-bit-period low glitch on rx in IDLE -> no byte received, FSM remains IDLE.

Source files
------------

// File: rtl/prog_loader.sv
// UART (8N1) program loader: receives a framed word stream and writes it to program memory.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing 16-bit sum check.
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic              prog_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              error
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LEN_HI  = 4'd1;
  localparam logic [3:0] ST_LEN_LO  = 4'd2;
  localparam logic [3:0] ST_DATA_HI = 4'd3;
  localparam logic [3:0] ST_DATA_LO = 4'd4;
  localparam logic [3:0] ST_CSUM_HI = 4'd5;
  localparam logic [3:0] ST_CSUM_LO = 4'd6;
  localparam logic [3:0] ST_DONE    = 4'd7;
  localparam logic [3:0] ST_ERR     = 4'd8;

  // ---------------------------------------------------------------- UART receiver
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]       ust_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             byte_valid_q, frame_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      ust_q        <= U_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (ust_q)
        U_IDLE: begin
          cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) ust_q <= U_START;
        end
        U_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A start bit that is gone by mid-bit is treated as a glitch.
            ust_q     <= rx_sync_q ? U_IDLE : U_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        U_DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            shreg_q <= {rx_sync_q, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) ust_q <= U_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q <= '0;
            ust_q <= U_IDLE;
            if (rx_sync_q) byte_valid_q <= 1'b1;
            else           frame_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- Load FSM
  logic [3:0]        state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       left_q, left_d;
  logic [ADDR_W-1:0] naddr_q, naddr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              go_start, go_done, go_err;
  logic [15:0]       word;
  logic [15:0]       len;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  assign word = {hi_q, shreg_q};
  assign len  = {hi_q, shreg_q};

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    left_d   = left_q;
    naddr_d  = naddr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    go_start = 1'b0;
    go_done  = 1'b0;
    go_err   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (byte_valid_q && shreg_q == SYNC_BYTE) go_start = 1'b1;
      end
      ST_LEN_HI: begin
        if (byte_valid_q) begin
          hi_d    = shreg_q;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (byte_valid_q) begin
          left_d = len;
          if (len == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = ST_CSUM_HI;
`else
            go_done = 1'b1;
`endif
          end else if ({1'b0, len} > MAX_WORDS) begin
            go_err = 1'b1;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (byte_valid_q) begin
          hi_d    = shreg_q;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (byte_valid_q) begin
          we_d    = 1'b1;
          data_d  = word;
          addr_d  = naddr_q;
          naddr_d = naddr_q + ADDR_W'(1);
          left_d  = left_q - 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = sum_q + word;
`endif
          if (left_q == 16'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = ST_CSUM_HI;
`else
            go_done = 1'b1;
`endif
          end else begin
            state_d = ST_DATA_HI;
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM_HI: begin
        if (byte_valid_q) begin
          hi_d    = shreg_q;
          state_d = ST_CSUM_LO;
        end
      end
      ST_CSUM_LO: begin
        if (byte_valid_q) begin
          if (word == sum_q) go_done = 1'b1;
          else               go_err  = 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A broken frame anywhere inside a load poisons the whole load.
    if (frame_err_q && state_q != ST_IDLE) go_err = 1'b1;

    hold_d = hold_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (go_start) begin
      state_d = ST_LEN_HI;
      naddr_d = '0;
      hold_d  = 1'b1;
      busy_d  = 1'b1;
      err_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else if (go_err) begin
      state_d = ST_ERR;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      hold_d  = 1'b1;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end else if (go_done) begin
      state_d = ST_DONE;
      hold_d  = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      left_q  <= '0;
      naddr_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      left_q  <= left_d;
      naddr_q <= naddr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign prog_addr = addr_q;
  assign prog_data = data_q;
  assign prog_we   = we_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;
  assign error     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: serialises framed byte streams onto rx and logs writes.
module tb_prog_loader;

  localparam int unsigned CPB    = 16;
  localparam int unsigned ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rx = 1'b1;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              prog_we;
  logic              cpu_hold;
  logic              busy;
  logic              error;

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_we   (prog_we),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] log_addr [0:63];
  logic [15:0]       log_data [0:63];
  int                wr_count = 0;
  int                we_run   = 0;
  int                we_long  = 0;
  int                unstable = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [15:0]       prev_data = '0;

  // Write logger plus strobe-width and hold-stable monitors.
  always @(negedge clk) begin
    if (prog_we) begin
      if (wr_count < 64) begin
        log_addr[wr_count] = prog_addr;
        log_data[wr_count] = prog_data;
      end
      wr_count = wr_count + 1;
      we_run   = we_run + 1;
      if (we_run > 1) we_long = we_long + 1;
    end else begin
      we_run = 0;
    end
    if (reset_n && !prog_we && (prog_addr !== prev_addr || prog_data !== prev_data))
      unstable = unstable + 1;
    prev_addr = prog_addr;
    prev_data = prog_data;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
  endtask

  task automatic send_stream(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(3);
    n_checks++; if (prog_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", prog_addr); end
    n_checks++; if (prog_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", prog_data); end
    n_checks++; if (prog_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", prog_we); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold got %b want 0", cpu_hold); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
    reset_n = 1'b1;
    tick(5);
  endtask

  task automatic test_basic_load;
    int base;
    logic [7:0] q[$];
    base = wr_count;
    send_byte(8'hA5, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_sync got %b want 1", busy); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL basic_hold_after_sync got %b want 1", cpu_hold); end
    q = {8'h00, 8'h02, 8'h12, 8'h34};
    send_stream(q);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL basic_hold_mid got %b want 1", cpu_hold); end
    n_checks++; if (wr_count - base !== 1) begin n_fail++; $display("FAIL basic_mid_writes got %0d want 1", wr_count - base); end
    q = {8'hAB, 8'hCD};
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(8'hBE); q.push_back(8'h01);
`endif
    send_stream(q);
    tick(4);
    n_checks++; if (wr_count - base !== 2) begin n_fail++; $display("FAIL basic_writes got %0d want 2", wr_count - base); end
    n_checks++; if (log_addr[base] !== 12'd0 || log_data[base] !== 16'h1234) begin n_fail++;
      $display("FAIL basic_w0 got %h@%h want 1234@000", log_data[base], log_addr[base]); end
    n_checks++; if (log_addr[base+1] !== 12'd1 || log_data[base+1] !== 16'hABCD) begin n_fail++;
      $display("FAIL basic_w1 got %h@%h want abcd@001", log_data[base+1], log_addr[base+1]); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_hold_done got %b want 0", cpu_hold); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done got %b want 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error got %b want 0", error); end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad;
    int base;
    logic [7:0] q[$];
    base = wr_count;
    q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h02};
    send_stream(q);
    tick(4);
    n_checks++; if (wr_count - base !== 2) begin n_fail++; $display("FAIL csum_writes got %0d want 2", wr_count - base); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL csum_error got %b want 1", error); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL csum_hold got %b want 1", cpu_hold); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL csum_busy got %b want 0", busy); end
  endtask
`endif

  task automatic test_len_limits;
    int base;
    logic [7:0] q[$];
    base = wr_count;
    // N = 4096 exactly fits a 12-bit address space and must be accepted.
    q = {8'hA5, 8'h10, 8'h00};
    send_stream(q);
    tick(4);
    n_checks++; if (busy !== 1'b1 || error !== 1'b0) begin n_fail++;
      $display("FAIL len_4096 got busy=%b error=%b want busy=1 error=0", busy, error); end
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    q = {8'hA5, 8'h10, 8'h01};
    send_stream(q);
    tick(4);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL len_4097_error got %b want 1", error); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL len_4097_hold got %b want 1", cpu_hold); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len_4097_busy got %b want 0", busy); end
    n_checks++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL len_writes got %0d want 0", wr_count - base); end
  endtask

  task automatic test_framing;
    int base;
    logic [7:0] q[$];
    base = wr_count;
    q = {8'hA5, 8'h00, 8'h02, 8'h12};
    send_stream(q);
    send_byte(8'h34, 1'b0);
    tick(4);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL frame_error got %b want 1", error); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL frame_hold got %b want 1", cpu_hold); end
    n_checks++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL frame_writes got %0d want 0", wr_count - base); end
    q = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h07};
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(8'h00); q.push_back(8'h07);
`endif
    send_stream(q);
    tick(4);
    n_checks++; if (wr_count - base !== 1) begin n_fail++; $display("FAIL frame_reload_writes got %0d want 1", wr_count - base); end
    n_checks++; if (log_addr[base] !== 12'd0 || log_data[base] !== 16'h0007) begin n_fail++;
      $display("FAIL frame_reload_w0 got %h@%h want 0007@000", log_data[base], log_addr[base]); end
    n_checks++; if (error !== 1'b0 || cpu_hold !== 1'b0) begin n_fail++;
      $display("FAIL frame_reload_flags got error=%b hold=%b want 0 0", error, cpu_hold); end
  endtask

  task automatic test_zero_len;
    int base;
    logic [7:0] q[$];
    base = wr_count;
    q = {8'hA5, 8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(8'h00); q.push_back(8'h00);
`endif
    send_stream(q);
    tick(4);
    n_checks++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL zero_writes got %0d want 0", wr_count - base); end
    n_checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0 || error !== 1'b0) begin n_fail++;
      $display("FAIL zero_flags got busy=%b hold=%b error=%b want 0 0 0", busy, cpu_hold, error); end
  endtask

  task automatic test_reset_midword;
    int base;
    logic [7:0] q[$];
    base = wr_count;
    q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_stream(q);
    // Start the CD byte, then pull reset part-way through it.
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB * 2);
    reset_n = 1'b0;
    #1;
    n_checks++; if (prog_data !== 16'h0 || prog_addr !== '0 || prog_we !== 1'b0) begin n_fail++;
      $display("FAIL midrst_mem_outs got %h@%h we=%b want 0000@000 we=0", prog_data, prog_addr, prog_we); end
    n_checks++; if (cpu_hold !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin n_fail++;
      $display("FAIL midrst_flags got hold=%b busy=%b error=%b want 0 0 0", cpu_hold, busy, error); end
    tick(2);
    reset_n = 1'b1;
    tick(CPB * 8);
    send_byte(8'hCD, 1'b1);
    tick(4);
    n_checks++; if (wr_count - base !== 1) begin n_fail++; $display("FAIL midrst_writes got %0d want 1", wr_count - base); end
    q = {8'hA5, 8'h00, 8'h01, 8'h55, 8'hAA};
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(8'h55); q.push_back(8'hAA);
`endif
    send_stream(q);
    tick(4);
    n_checks++; if (wr_count - base !== 2) begin n_fail++; $display("FAIL midrst_reload_writes got %0d want 2", wr_count - base); end
    n_checks++; if (log_addr[base+1] !== 12'd0 || log_data[base+1] !== 16'h55AA) begin n_fail++;
      $display("FAIL midrst_reload_w0 got %h@%h want 55aa@000", log_data[base+1], log_addr[base+1]); end
  endtask

  task automatic test_glitch;
    int base;
    logic [7:0] q[$];
    base = wr_count;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(CPB);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", busy); end
    q = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h09};
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(8'h00); q.push_back(8'h09);
`endif
    send_stream(q);
    tick(4);
    n_checks++; if (wr_count - base !== 1) begin n_fail++; $display("FAIL glitch_writes got %0d want 1", wr_count - base); end
    n_checks++; if (log_addr[base] !== 12'd0 || log_data[base] !== 16'h0009) begin n_fail++;
      $display("FAIL glitch_w0 got %h@%h want 0009@000", log_data[base], log_addr[base]); end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [7:0] q[$];
    base = wr_count;
    q = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(8'h66); q.push_back(8'h66);
`endif
    q.push_back(8'hA5); q.push_back(8'h00); q.push_back(8'h01);
    q.push_back(8'h44); q.push_back(8'h44);
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(8'h44); q.push_back(8'h44);
`endif
    send_stream(q);
    tick(4);
    n_checks++; if (wr_count - base !== 4) begin n_fail++; $display("FAIL b2b_writes got %0d want 4", wr_count - base); end
    n_checks++; if (log_addr[base] !== 12'd0 || log_data[base] !== 16'h1111) begin n_fail++;
      $display("FAIL b2b_w0 got %h@%h want 1111@000", log_data[base], log_addr[base]); end
    n_checks++; if (log_addr[base+1] !== 12'd1 || log_data[base+1] !== 16'h2222) begin n_fail++;
      $display("FAIL b2b_w1 got %h@%h want 2222@001", log_data[base+1], log_addr[base+1]); end
    n_checks++; if (log_addr[base+2] !== 12'd2 || log_data[base+2] !== 16'h3333) begin n_fail++;
      $display("FAIL b2b_w2 got %h@%h want 3333@002", log_data[base+2], log_addr[base+2]); end
    n_checks++; if (log_addr[base+3] !== 12'd0 || log_data[base+3] !== 16'h4444) begin n_fail++;
      $display("FAIL b2b_w3 got %h@%h want 4444@000", log_data[base+3], log_addr[base+3]); end
    n_checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0 || error !== 1'b0) begin n_fail++;
      $display("FAIL b2b_flags got busy=%b hold=%b error=%b want 0 0 0", busy, cpu_hold, error); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_len_limits();
    test_framing();
    test_zero_len();
    test_reset_midword();
    test_glitch();
    test_back_to_back();
    n_checks++; if (we_long !== 0) begin n_fail++; $display("FAIL we_width got %0d long strobes want 0", we_long); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL hold_stable got %0d changes want 0", unstable); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
